// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared widths, size codes, state encodings and load helpers
//            for the byte-serial memory controller.
// Revision : 1.0
// ============================================================================
package mem_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int CNT_WIDTH  = 3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [CNT_WIDTH-1:0] FETCH_LEN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_FETCH     = 2'b01,
        ST_LSB_READ  = 2'b10,
        ST_LSB_WRITE = 2'b11
    } state_t;

    // Size code 2'b11 behaves as a word access.
    function automatic logic [CNT_WIDTH-1:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [CNT_WIDTH-1:0]  len,
        input logic                  sgn
    );
        logic [DATA_WIDTH-1:0] res;
        case (len)
            3'd1:    res = {{24{sgn & raw[7]}}, raw[7:0]};
            3'd2:    res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Arbitrates instruction fetch and load/store requests onto a
//            byte-wide RAM, one byte per cycle, little-endian.
// Revision : 1.0
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_clear,

    input  logic                  in_fetch_req,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
    output logic                  out_fetch_done,
    output logic [DATA_WIDTH-1:0] out_fetch_data,

    input  logic                  in_lsb_req,
    input  logic                  in_lsb_wr,
    input  logic [1:0]            in_lsb_size,
    input  logic                  in_lsb_signed,
    input  logic [ADDR_WIDTH-1:0] in_lsb_addr,
    input  logic [DATA_WIDTH-1:0] in_lsb_wdata,
    output logic                  out_lsb_done,
    output logic [DATA_WIDTH-1:0] out_lsb_rdata,

    output logic [ADDR_WIDTH-1:0] out_ram_addr,
    output logic                  out_ram_wr,
    output logic [BYTE_WIDTH-1:0] out_ram_wdata,
    input  logic [BYTE_WIDTH-1:0] in_ram_rdata
);

    state_t                 state_q,      state_d;
    logic [CNT_WIDTH-1:0]   cnt_q,        cnt_d;
    logic [CNT_WIDTH-1:0]   len_q,        len_d;
    logic [ADDR_WIDTH-1:0]  addr_q,       addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,      wdata_d;
    logic [DATA_WIDTH-1:0]  buf_q,        buf_d;
    logic                   sgn_q,        sgn_d;
    logic                   last_lsb_q,   last_lsb_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q,   ram_addr_d;
    logic                   ram_wr_q,     ram_wr_d;
    logic [BYTE_WIDTH-1:0]  ram_wdata_q,  ram_wdata_d;
    logic                   fetch_done_q, fetch_done_d;
    logic                   lsb_done_q,   lsb_done_d;
    logic [DATA_WIDTH-1:0]  fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0]  lsb_rdata_q,  lsb_rdata_d;

    logic                   w_fetch_elig;
    logic                   w_lsb_elig;
    logic                   w_grant_lsb;
    logic                   w_grant_fetch;
    logic [CNT_WIDTH-1:0]   w_next_idx;
    logic [1:0]             w_cap_idx;
    logic [ADDR_WIDTH-1:0]  w_issue_addr;
    logic [DATA_WIDTH-1:0]  w_captured;

    // A pending flush blocks speculative reads; stores are still accepted.
    assign w_fetch_elig  = in_fetch_req & ~in_clear;
    assign w_lsb_elig    = in_lsb_req & (in_lsb_wr | ~in_clear);
    assign w_grant_lsb   = w_lsb_elig & (~w_fetch_elig | ~last_lsb_q);
    assign w_grant_fetch = w_fetch_elig & ~w_grant_lsb;

    // cnt_q is the index of the current cycle after grant minus one.
    assign w_next_idx    = cnt_q + 3'd1;
    assign w_cap_idx     = cnt_q[1:0] - 2'd1;
    assign w_issue_addr  = addr_q + {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, w_next_idx};

    always_comb begin
        w_captured = buf_q;
        w_captured[{w_cap_idx, 3'b000} +: BYTE_WIDTH] = in_ram_rdata;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        sgn_d        = sgn_q;
        last_lsb_d   = last_lsb_q;
        ram_addr_d   = '0;
        ram_wr_d     = 1'b0;
        ram_wdata_d  = '0;
        fetch_done_d = 1'b0;
        lsb_done_d   = 1'b0;
        fetch_data_d = fetch_data_q;
        lsb_rdata_d  = lsb_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                buf_d = '0;
                if (w_grant_lsb) begin
                    state_d     = in_lsb_wr ? ST_LSB_WRITE : ST_LSB_READ;
                    addr_d      = in_lsb_addr;
                    len_d       = size_to_len(in_lsb_size);
                    sgn_d       = in_lsb_signed;
                    wdata_d     = in_lsb_wdata;
                    last_lsb_d  = 1'b1;
                    ram_addr_d  = in_lsb_addr;
                    ram_wr_d    = in_lsb_wr;
                    ram_wdata_d = in_lsb_wr ? in_lsb_wdata[BYTE_WIDTH-1:0] : '0;
                end else if (w_grant_fetch) begin
                    state_d     = ST_FETCH;
                    addr_d      = in_fetch_addr;
                    len_d       = FETCH_LEN;
                    sgn_d       = 1'b0;
                    wdata_d     = '0;
                    last_lsb_d  = 1'b0;
                    ram_addr_d  = in_fetch_addr;
                end
            end

            ST_FETCH, ST_LSB_READ: begin
                if (in_clear) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != '0) begin
                        buf_d = w_captured;
                    end
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (state_q == ST_FETCH) begin
                            fetch_done_d = 1'b1;
                            fetch_data_d = w_captured;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = extend_load(w_captured, len_q, sgn_q);
                        end
                    end else begin
                        cnt_d = w_next_idx;
                        if (w_next_idx < len_q) begin
                            ram_addr_d = w_issue_addr;
                        end
                    end
                end
            end

            ST_LSB_WRITE: begin
                if (w_next_idx < len_q) begin
                    cnt_d       = w_next_idx;
                    ram_addr_d  = w_issue_addr;
                    ram_wr_d    = 1'b1;
                    ram_wdata_d = wdata_q[{w_next_idx[1:0], 3'b000} +: BYTE_WIDTH];
                end else begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    lsb_done_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            sgn_q        <= 1'b0;
            last_lsb_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wr_q     <= 1'b0;
            ram_wdata_q  <= '0;
            fetch_done_q <= 1'b0;
            lsb_done_q   <= 1'b0;
            fetch_data_q <= '0;
            lsb_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            sgn_q        <= sgn_d;
            last_lsb_q   <= last_lsb_d;
            ram_addr_q   <= ram_addr_d;
            ram_wr_q     <= ram_wr_d;
            ram_wdata_q  <= ram_wdata_d;
            fetch_done_q <= fetch_done_d;
            lsb_done_q   <= lsb_done_d;
            fetch_data_q <= fetch_data_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    assign out_fetch_done = fetch_done_q;
    assign out_fetch_data = fetch_data_q;
    assign out_lsb_done   = lsb_done_q;
    assign out_lsb_rdata  = lsb_rdata_q;
    assign out_ram_addr   = ram_addr_q;
    assign out_ram_wr     = ram_wr_q;
    assign out_ram_wdata  = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Directed bench for mem_ctrl with a byte-wide RAM model.
// Revision : 1.0
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_clear = 1'b0;
    logic        in_fetch_req = 1'b0;
    logic [31:0] in_fetch_addr = '0;
    logic        out_fetch_done;
    logic [31:0] out_fetch_data;
    logic        in_lsb_req = 1'b0;
    logic        in_lsb_wr = 1'b0;
    logic [1:0]  in_lsb_size = '0;
    logic        in_lsb_signed = 1'b0;
    logic [31:0] in_lsb_addr = '0;
    logic [31:0] in_lsb_wdata = '0;
    logic        out_lsb_done;
    logic [31:0] out_lsb_rdata;
    logic [31:0] out_ram_addr;
    logic        out_ram_wr;
    logic [7:0]  out_ram_wdata;
    logic [7:0]  in_ram_rdata = '0;

    always #5 clk = ~clk;

    mem_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .in_clear       (in_clear),
        .in_fetch_req   (in_fetch_req),
        .in_fetch_addr  (in_fetch_addr),
        .out_fetch_done (out_fetch_done),
        .out_fetch_data (out_fetch_data),
        .in_lsb_req     (in_lsb_req),
        .in_lsb_wr      (in_lsb_wr),
        .in_lsb_size    (in_lsb_size),
        .in_lsb_signed  (in_lsb_signed),
        .in_lsb_addr    (in_lsb_addr),
        .in_lsb_wdata   (in_lsb_wdata),
        .out_lsb_done   (out_lsb_done),
        .out_lsb_rdata  (out_lsb_rdata),
        .out_ram_addr   (out_ram_addr),
        .out_ram_wr     (out_ram_wr),
        .out_ram_wdata  (out_ram_wdata),
        .in_ram_rdata   (in_ram_rdata)
    );

    // RAM model: 8 KiB window aliased on addr[12:0], read data one cycle late.
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        in_ram_rdata <= mem[out_ram_addr[12:0]];
        if (out_ram_wr) mem[out_ram_addr[12:0]] = out_ram_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bus();
        return {23'b0, out_ram_addr, out_ram_wr, out_ram_wdata};
    endfunction

    function automatic int ev_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic drop_reqs();
        in_fetch_req = 1'b0;
        in_lsb_req   = 1'b0;
    endtask

    task automatic drive_lsb(input logic wr, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        in_lsb_req    = 1'b1;
        in_lsb_wr     = wr;
        in_lsb_size   = size;
        in_lsb_signed = sgn;
        in_lsb_addr   = addr;
        in_lsb_wdata  = wdata;
    endtask

    typedef struct {
        logic        fetch;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          n;
        logic        done;
        logic [63:0] exp_bus;
        n = v.fetch ? 4 : (v.size == 2'b00 ? 1 : (v.size == 2'b01 ? 2 : 4));
        @(negedge clk);
        if (v.fetch) begin
            in_fetch_req  = 1'b1;
            in_fetch_addr = v.addr;
        end else begin
            drive_lsb(v.wr, v.size, v.sgn, v.addr, v.wdata);
        end
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 16) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            done = v.fetch ? out_fetch_done : out_lsb_done;
            if (!done) begin
                if (lat <= n)
                    exp_bus = {23'b0, v.addr + 32'(lat - 1), v.wr,
                               v.wr ? v.wdata[8*(lat-1) +: 8] : 8'h00};
                else
                    exp_bus = '0;
                check($sformatf("v%0d ram_bus c%0d", idx, lat), bus(), exp_bus);
            end
        end
        drop_reqs();
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d data", idx), v.fetch ? out_fetch_data : out_lsb_rdata, v.exp_data);
        check($sformatf("v%0d bus_idle_at_done", idx), bus(), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d done_single_pulse", idx), {out_fetch_done, out_lsb_done}, 64'd0);
    endtask

    int lsb_ev[$];
    int fet_ev[$];

    initial begin
        int lat;
        int fseen;
        int dseen;
        logic got;

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h1000] = 8'h13; mem[13'h1001] = 8'h05;
        mem[13'h0020] = 8'h80;
        mem[13'h0040] = 8'h34; mem[13'h0041] = 8'h92;
        mem[13'h1FFE] = 8'hAA; mem[13'h1FFF] = 8'h11;
        mem[13'h0000] = 8'h22; mem[13'h0001] = 8'h33;

        //          fetch wr  size   sgn   addr           wdata          exp_data       lat
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0513, 6};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'hFFFF_FF80, 3};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080, 3};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0,         32'hFFFF_9234, 4};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_9234, 4};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0,         32'hFFFF_FF92, 3};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_2211, 4};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h3322_11AA, 6};
        vecs[8]  = '{1'b0, 1'b0, 2'b11, 1'b1, 32'h0000_1000, 32'h0,         32'h0000_0513, 6};
        vecs[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'hDEAD_BEEF, 32'h0000_0513, 5};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0200, 32'h1234_55AA, 32'hDEAD_BEEF, 3};
        vecs[12] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0202, 32'hFFFF_FF77, 32'hDEAD_BEEF, 2};
        vecs[13] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         32'h0077_55AA, 6};
        vecs[14] = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0201, 32'h0,         32'h0000_7755, 4};

        // Reset state
        #1;
        check("rst fetch_done", 64'(out_fetch_done), 64'd0);
        check("rst lsb_done",   64'(out_lsb_done),   64'd0);
        check("rst fetch_data", 64'(out_fetch_data), 64'd0);
        check("rst lsb_rdata",  64'(out_lsb_rdata),  64'd0);
        check("rst ram_bus",    bus(),               64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Both requesters pending from reset: LSB first, then strict alternation
        @(negedge clk);
        in_fetch_req  = 1'b1;
        in_fetch_addr = 32'h0000_1000;
        drive_lsb(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_lsb_done)   lsb_ev.push_back(e);
            if (out_fetch_done) fet_ev.push_back(e);
            if (e == 18) drop_reqs();
        end
        check("arb lsb_done count",   64'(lsb_ev.size()), 64'd2);
        check("arb fetch_done count", 64'(fet_ev.size()), 64'd2);
        check("arb lsb_done #1 edge",   64'(ev_at(lsb_ev, 0)), 64'd3);
        check("arb fetch_done #1 edge", 64'(ev_at(fet_ev, 0)), 64'd9);
        check("arb lsb_done #2 edge",   64'(ev_at(lsb_ev, 1)), 64'd12);
        check("arb fetch_done #2 edge", 64'(ev_at(fet_ev, 1)), 64'd18);
        check("arb fetch_data", 64'(out_fetch_data), 64'h0000_0513);
        check("arb lsb_rdata",  64'(out_lsb_rdata),  64'h0000_0080);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);
        check("wr word byte @101", 64'(mem[13'h0101]), 64'hEF);
        check("wr word byte @104", 64'(mem[13'h0104]), 64'hDE);

        // Flush during cycle 2 of a fetch aborts it
        @(negedge clk);
        in_fetch_req  = 1'b1;
        in_fetch_addr = 32'h0000_0040;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        in_clear = 1'b1;
        @(posedge clk); @(negedge clk);
        in_clear     = 1'b0;
        in_fetch_req = 1'b0;
        fseen = out_fetch_done ? 1 : 0;
        check("clr_fetch bus idle", bus(), 64'd0);
        drive_lsb(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (out_fetch_done) fseen++;
            if (out_lsb_done)   got = 1'b1;
        end
        drop_reqs();
        check("clr_fetch next grant latency", 64'(lat), 64'd3);
        check("clr_fetch no fetch_done", 64'(fseen), 64'd0);
        check("clr_fetch fetch_data kept", 64'(out_fetch_data), 64'h3322_11AA);
        check("clr_fetch lsb_rdata", 64'(out_lsb_rdata), 64'h0000_0080);

        // Flush during cycle 2 of a half store is ignored
        @(negedge clk);
        drive_lsb(1'b1, 2'b01, 1'b0, 32'h0000_0300, 32'h0000_C3D4);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        in_clear = 1'b1;
        @(posedge clk); @(negedge clk);
        in_clear = 1'b0;
        check("clr_wr done", 64'(out_lsb_done), 64'd1);
        drop_reqs();
        check("clr_wr byte @300", 64'(mem[13'h0300]), 64'hD4);
        check("clr_wr byte @301", 64'(mem[13'h0301]), 64'hC3);
        check("clr_wr rdata kept", 64'(out_lsb_rdata), 64'h0000_0080);
        @(posedge clk); @(negedge clk);
        check("clr_wr done pulse", 64'(out_lsb_done), 64'd0);

        // Flush in IDLE blocks reads but still admits a store
        @(negedge clk);
        in_clear      = 1'b1;
        in_fetch_req  = 1'b1;
        in_fetch_addr = 32'h0000_1000;
        drive_lsb(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0);
        @(posedge clk); @(negedge clk);
        check("clr_idle reads blocked", bus(), 64'd0);
        in_fetch_req = 1'b0;
        drive_lsb(1'b1, 2'b00, 1'b0, 32'h0000_0400, 32'h0000_005A);
        @(posedge clk); @(negedge clk);
        check("clr_idle store granted", bus(), {23'b0, 32'h0000_0400, 1'b1, 8'h5A});
        @(posedge clk); @(negedge clk);
        check("clr_idle store done", 64'(out_lsb_done), 64'd1);
        drop_reqs();
        in_clear = 1'b0;
        check("clr_idle byte @400", 64'(mem[13'h0400]), 64'h5A);

        // Asynchronous reset in the middle of a word load
        @(negedge clk);
        drive_lsb(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        #2 rst = 1'b1;
        drop_reqs();
        #1;
        check("arst fetch_done", 64'(out_fetch_done), 64'd0);
        check("arst lsb_done",   64'(out_lsb_done),   64'd0);
        check("arst fetch_data", 64'(out_fetch_data), 64'd0);
        check("arst lsb_rdata",  64'(out_lsb_rdata),  64'd0);
        check("arst ram_bus",    bus(),               64'd0);
        @(negedge clk);
        rst = 1'b0;
        dseen = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (out_fetch_done || out_lsb_done) dseen++;
        end
        check("arst no done after release", 64'(dseen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
